// File: rtl/cpu_trace_emitter.sv
// Serializes one CPU write-back record per request into the ASCII trace stream,
// one character per valid/ready transfer, with the binary time printed in decimal.
//
// state | meaning
// IDLE  | waiting for start; fields are latched on accept
// CONV  | 14 double-dabble steps turn the time into 4 BCD digits
// EMIT  | walking the character template, one character per transfer
module cpu_trace_emitter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        fmt,
    input  logic [13:0] time_in,
    input  logic [31:0] pc_in,
    input  logic [4:0]  grf_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    input  logic        out_ready,
    output logic [7:0]  char,
    output logic        char_valid,
    output logic        busy,
    output logic        done,
    output logic        clamped
);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_EMIT} state_t;

    localparam logic [5:0] POS_LAST = 6'd37;

    state_t      state_q, state_d;
    logic        fmt_q, fmt_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  grf_q, grf_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [29:0] conv_q, conv_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  pos_q, pos_d;
    logic        done_q, done_d;
    logic        clamped_q, clamped_d;

    logic [13:0] time_sat;
    logic [15:0] bcd;
    logic [5:0]  t_start;
    logic [1:0]  g_tens;
    logic [4:0]  g_sub;
    logic [3:0]  g_units;
    logic [5:0]  pos_nxt;
    logic [7:0]  ch;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    function automatic logic [3:0] nib_at(input logic [31:0] w, input logic [2:0] idx);
        logic [31:0] s;
        s = w >> {idx, 2'b00};
        return s[3:0];
    endfunction

    // One shift-add-3 step over {bcd[15:0], bin[13:0]}
    function automatic logic [29:0] dd_step(input logic [29:0] v);
        logic [29:0] a;
        a = v;
        for (int i = 0; i < 4; i++) begin
            if (a[14+4*i +: 4] >= 4'd5) a[14+4*i +: 4] = a[14+4*i +: 4] + 4'd3;
        end
        return {a[28:0], 1'b0};
    endfunction

    assign time_sat = (time_in > 14'd9999) ? 14'd9999 : time_in;
    assign bcd      = conv_q[29:14];

    always_comb begin
        t_start = 6'd4;
        if (bcd[15:12] != 4'd0)      t_start = 6'd1;
        else if (bcd[11:8] != 4'd0)  t_start = 6'd2;
        else if (bcd[7:4] != 4'd0)   t_start = 6'd3;

        g_tens = 2'd0;
        g_sub  = 5'd0;
        if (grf_q >= 5'd30)      begin g_tens = 2'd3; g_sub = 5'd30; end
        else if (grf_q >= 5'd20) begin g_tens = 2'd2; g_sub = 5'd20; end
        else if (grf_q >= 5'd10) begin g_tens = 2'd1; g_sub = 5'd10; end
        g_units = 4'(grf_q - g_sub);

        // Template positions 1..4 hold time digits, 17..24 hold the address or, for
        // register records, the grf digits at 23..24; leading positions are jumped over.
        pos_nxt = pos_q + 6'd1;
        if (pos_nxt == 6'd1)                 pos_nxt = t_start;
        else if (pos_nxt == 6'd17 && !fmt_q) pos_nxt = (g_tens != 2'd0) ? 6'd23 : 6'd24;
    end

    always_comb begin
        ch = 8'h00;
        case (pos_q) inside
            6'd0:            ch = 8'h5e;
            6'd1:            ch = 8'h30 + {4'h0, bcd[15:12]};
            6'd2:            ch = 8'h30 + {4'h0, bcd[11:8]};
            6'd3:            ch = 8'h30 + {4'h0, bcd[7:4]};
            6'd4:            ch = 8'h30 + {4'h0, bcd[3:0]};
            6'd5:            ch = 8'h40;
            [6'd6:6'd13]:    ch = hex_char(nib_at(pc_q, 3'(6'd13 - pos_q)));
            6'd14:           ch = 8'h3a;
            6'd15:           ch = 8'h20;
            6'd16:           ch = fmt_q ? 8'h2a : 8'h24;
            [6'd17:6'd24]: begin
                if (fmt_q)              ch = hex_char(nib_at(addr_q, 3'(6'd24 - pos_q)));
                else if (pos_q == 6'd23) ch = 8'h30 + {6'h0, g_tens};
                else                     ch = 8'h30 + {4'h0, g_units};
            end
            6'd25, 6'd28:    ch = 8'h20;
            6'd26:           ch = 8'h3c;
            6'd27:           ch = 8'h3d;
            [6'd29:6'd36]:   ch = hex_char(nib_at(data_q, 3'(6'd36 - pos_q)));
            6'd37:           ch = 8'h23;
            default:         ch = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        fmt_d     = fmt_q;
        pc_d      = pc_q;
        grf_d     = grf_q;
        addr_d    = addr_q;
        data_d    = data_q;
        conv_d    = conv_q;
        cnt_d     = cnt_q;
        pos_d     = pos_q;
        done_d    = 1'b0;
        clamped_d = clamped_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CONV;
                    fmt_d     = fmt;
                    pc_d      = pc_in;
                    grf_d     = grf_in;
                    addr_d    = addr_in;
                    data_d    = data_in;
                    conv_d    = {16'd0, time_sat};
                    cnt_d     = 4'd13;
                    pos_d     = 6'd0;
                    clamped_d = (time_in > 14'd9999);
                end
            end
            S_CONV: begin
                conv_d = dd_step(conv_q);
                if (cnt_q == 4'd0) state_d = S_EMIT;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (pos_q == POS_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        pos_d = pos_nxt;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            fmt_q     <= 1'b0;
            pc_q      <= 32'd0;
            grf_q     <= 5'd0;
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            conv_q    <= 30'd0;
            cnt_q     <= 4'd0;
            pos_q     <= 6'd0;
            done_q    <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fmt_q     <= fmt_d;
            pc_q      <= pc_d;
            grf_q     <= grf_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            conv_q    <= conv_d;
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            done_q    <= done_d;
            clamped_q <= clamped_d;
        end
    end

    assign char_valid = (state_q == S_EMIT);
    assign char       = char_valid ? ch : 8'h00;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign clamped    = clamped_q;

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Directed bench for cpu_trace_emitter: captures each emitted record and compares it
// against hand-written expected strings and cycle counts.
module tb_cpu_trace_emitter;

    logic        clk = 1'b0;
    logic        reset, start, fmt, out_ready;
    logic [13:0] time_in;
    logic [31:0] pc_in, addr_in, data_in;
    logic [4:0]  grf_in;
    logic [7:0]  char;
    logic        char_valid, busy, done, clamped;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    cpu_trace_emitter dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .fmt        (fmt),
        .time_in    (time_in),
        .pc_in      (pc_in),
        .grf_in     (grf_in),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .out_ready  (out_ready),
        .char       (char),
        .char_valid (char_valid),
        .busy       (busy),
        .done       (done),
        .clamped    (clamped)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_s(input string tag, input string obs, input string exp);
        total++;
        assert (obs == exp) passed++;
        else $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
    endtask

    task automatic set_fields(input logic f, input logic [13:0] t, input logic [31:0] p,
                              input logic [4:0] g, input logic [31:0] a, input logic [31:0] d);
        fmt = f; time_in = t; pc_in = p; grf_in = g; addr_in = a; data_in = d;
    endtask

    task automatic junk(input logic f);
        set_fields(f, 14'd16000, 32'h13579bdf, 5'd19, 32'h2468ace0, 32'h0badf00d);
    endtask

    task automatic accept(input bit hold);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        chk("busy_after_accept", busy, 1);
    endtask

    // Collects one record; optional stall on '@', start pulse or reset abort at a char count.
    task automatic capture(output string s, output int edges, output int first_edge,
                           input int stall_n, input int pulse_at, input int abort_at);
        int         got;
        int         stalls;
        bit         xfer;
        bit         fin;
        logic [7:0] c;
        got = 0; stalls = stall_n; fin = 0;
        s = ""; edges = 0; first_edge = -1;
        for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge clk);
            if (abort_at >= 0 && got == abort_at) begin
                reset = 1'b1;
                #1;
                chk("abort_char", char, 0);
                chk("abort_valid", char_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_clamped", clamped, 0);
                return;
            end
            if (char_valid && first_edge < 0) first_edge = edges;
            if (char_valid && char == 8'h40 && stalls > 0) begin
                out_ready = 1'b0;
                stalls--;
            end else begin
                out_ready = 1'b1;
            end
            if (pulse_at >= 0) start = (got == pulse_at);
            xfer = char_valid && out_ready;
            c = char;
            @(posedge clk);
            edges++;
            if (xfer) begin
                s = $sformatf("%s%c", s, c);
                got++;
                if (c == 8'h23) fin = 1;
            end
        end
        out_ready = 1'b1;
        if (pulse_at >= 0) start = 1'b0;
        chk("record_terminated", fin, 1);
        #1;
        chk("end_busy", busy, 0);
        chk("end_valid", char_valid, 0);
        chk("end_done", done, 1);
    endtask

    initial begin
        string s;
        int    edges, first;
        bit    stray;

        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        set_fields(1'b0, 14'd0, 32'd0, 5'd0, 32'd0, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_char", char, 0);
        chk("rst_valid", char_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_clamped", clamped, 0);
        @(negedge clk); reset = 1'b0;

        // Register record
        set_fields(1'b0, 14'd2, 32'hee2a8ee8, 5'd7, 32'h0, 32'h0a8a4630);
        accept(0); junk(1'b1);
        capture(s, edges, first, 0, -1, -1);
        chk_s("reg_str", s, "^2@ee2a8ee8: $7 <= 0a8a4630#");
        chk("reg_edges", edges, 42);
        chk("reg_first", first, 14);
        chk("reg_clamped", clamped, 0);
        @(posedge clk); #1;
        chk("done_pulse_one_cycle", done, 0);

        // Memory record
        set_fields(1'b1, 14'd9, 32'h88b7621a, 5'd0, 32'h0daca7ae, 32'h79fd1df4);
        accept(0); junk(1'b0);
        capture(s, edges, first, 0, -1, -1);
        chk_s("mem_str", s, "^9@88b7621a: *0daca7ae <= 79fd1df4#");
        chk("mem_edges", edges, 49);

        // Decimal edges
        set_fields(1'b0, 14'd0, 32'h12345678, 5'd0, 32'h0, 32'hdeadbeef);
        accept(0); junk(1'b1);
        capture(s, edges, first, 0, -1, -1);
        chk_s("zero_str", s, "^0@12345678: $0 <= deadbeef#");
        chk("zero_edges", edges, 42);

        set_fields(1'b0, 14'd9999, 32'hcafef00d, 5'd31, 32'h0, 32'h00000001);
        accept(0); junk(1'b1);
        capture(s, edges, first, 0, -1, -1);
        chk_s("max_str", s, "^9999@cafef00d: $31 <= 00000001#");
        chk("max_edges", edges, 46);
        chk("max_clamped", clamped, 0);

        set_fields(1'b1, 14'd1000, 32'h00000000, 5'd3, 32'hffffffff, 32'h80000000);
        accept(0); junk(1'b0);
        capture(s, edges, first, 0, -1, -1);
        chk_s("k_str", s, "^1000@00000000: *ffffffff <= 80000000#");
        chk("k_edges", edges, 52);

        set_fields(1'b0, 14'd12000, 32'ha5a5a5a5, 5'd10, 32'h0, 32'h5a5a5a5a);
        accept(0); junk(1'b1);
        chk("clamp_set", clamped, 1);
        capture(s, edges, first, 0, -1, -1);
        chk_s("clamp_str", s, "^9999@a5a5a5a5: $10 <= 5a5a5a5a#");
        chk("clamp_edges", edges, 46);
        chk("clamp_held", clamped, 1);

        // Backpressure on '@'; also clears the clamp flag on accept
        set_fields(1'b0, 14'd2, 32'hee2a8ee8, 5'd7, 32'h0, 32'h0a8a4630);
        accept(0); junk(1'b1);
        chk("clamp_cleared", clamped, 0);
        capture(s, edges, first, 3, -1, -1);
        chk_s("bp_str", s, "^2@ee2a8ee8: $7 <= 0a8a4630#");
        chk("bp_edges", edges, 45);

        // start during EMIT is ignored
        set_fields(1'b1, 14'd9, 32'h88b7621a, 5'd0, 32'h0daca7ae, 32'h79fd1df4);
        accept(0); junk(1'b0);
        capture(s, edges, first, 0, 10, -1);
        chk_s("coll_str", s, "^9@88b7621a: *0daca7ae <= 79fd1df4#");
        chk("coll_edges", edges, 49);
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (busy) stray = 1;
        end
        chk("coll_no_second", stray, 0);

        // Reset in the data field, then a clean record
        set_fields(1'b0, 14'd2, 32'hee2a8ee8, 5'd7, 32'h0, 32'h0a8a4630);
        accept(0); junk(1'b1);
        capture(s, edges, first, 0, -1, 20);
        @(negedge clk); reset = 1'b0;
        set_fields(1'b0, 14'd0, 32'h12345678, 5'd0, 32'h0, 32'hdeadbeef);
        accept(0); junk(1'b1);
        capture(s, edges, first, 0, -1, -1);
        chk_s("post_rst_str", s, "^0@12345678: $0 <= deadbeef#");
        chk("post_rst_edges", edges, 42);

        // Back-to-back with start held high
        set_fields(1'b0, 14'd2, 32'hee2a8ee8, 5'd7, 32'h0, 32'h0a8a4630);
        accept(1);
        set_fields(1'b1, 14'd9, 32'h88b7621a, 5'd0, 32'h0daca7ae, 32'h79fd1df4);
        capture(s, edges, first, 0, -1, -1);
        chk_s("b2b1_str", s, "^2@ee2a8ee8: $7 <= 0a8a4630#");
        chk("b2b1_edges", edges, 42);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b2_accepted", busy, 1);
        junk(1'b0);
        capture(s, edges, first, 0, -1, -1);
        chk_s("b2b2_str", s, "^9@88b7621a: *0daca7ae <= 79fd1df4#");
        chk("b2b2_edges", edges, 49);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
